// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O bus: controller states,
// address-region codes and the memop width.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [11:0] REGION_IMEM = 12'h000;
  localparam logic [11:0] REGION_DMEM = 12'h001;
  localparam logic [11:0] REGION_VGA  = 12'h002;
  localparam logic [11:0] REGION_PS2  = 12'h003;

  localparam int MEMOP_W = 3;

endpackage

// File: rtl/mmio_decode.sv
// Region decoder: maps an address region code onto a slave index, given the
// code of slave 0 and the number of slaves. Shared with the fetch checker.
module mmio_decode (
  input  logic [11:0] i_code,
  input  logic [11:0] i_base,
  input  logic [3:0]  i_num,
  output logic        o_hit,
  output logic [2:0]  o_idx
);

  logic [11:0] w_diff;

  // The subtraction wraps below the base, so the >= test guards that case.
  assign w_diff = i_code - i_base;
  assign o_hit  = (i_code >= i_base) && (w_diff < {8'd0, i_num});
  assign o_idx  = w_diff[2:0];

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Single-transaction MMIO bus controller: decodes the core's request onto a
// one-hot slave strobe, waits for ack or timeout and returns registered results.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int          NUM_SLAVES = 3,
  parameter logic [11:0] BASE_CODE  = 12'h001,
  parameter int          TIMEOUT    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       m_re,
  input  logic                       m_we,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [MEMOP_W-1:0]         m_op,
  output logic [31:0]                m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [31:0]                err_addr,
  output logic [NUM_SLAVES-1:0]      s_re,
  output logic [NUM_SLAVES-1:0]      s_we,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [MEMOP_W-1:0]         s_op,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ack,
  output logic [1:0]                 dbg_state
);

  // Handshake: the core pulses m_re/m_we for one cycle while the controller is
  // idle and must not issue again until m_ready; a slave holds s_ack high for
  // the cycle in which it completes, and the controller samples it on the edge.

  state_t                  r_state, w_next;
  logic [31:0]             r_rdata, r_err_addr, r_addr, r_wdata;
  logic [MEMOP_W-1:0]      r_op;
  logic                    r_ready, r_err, r_wr;
  logic [2:0]              r_idx;
  logic [7:0]              r_cnt;
  logic [NUM_SLAVES-1:0]   r_s_re, r_s_we;

  logic                    w_req, w_hit, w_ack_sel, w_timeout;
  logic [2:0]              w_idx;
  logic [NUM_SLAVES-1:0]   w_onehot;
  logic [31:0]             w_rdata_sel;

  mmio_decode u_decode (
    .i_code (m_addr[31:20]),
    .i_base (BASE_CODE),
    .i_num  (4'(NUM_SLAVES)),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_req = m_re | m_we;

  always_comb begin
    w_onehot    = '0;
    w_ack_sel   = 1'b0;
    w_rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_onehot[i] = (w_idx == i[2:0]);
      if (r_idx == i[2:0]) begin
        w_ack_sel   = s_ack[i];
        w_rdata_sel = s_rdata[32*i +: 32];
      end
    end
  end

  // An ack in the final allowed cycle still counts as a success.
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1)) && !w_ack_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_hit ? BUSY : DONE;
      BUSY:    if (w_ack_sel || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata    <= '0;
      r_err_addr <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op       <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_wr       <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_s_re     <= '0;
      r_s_we     <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_op    <= m_op;
            r_wr    <= m_we;
            r_idx   <= w_idx;
            r_cnt   <= '0;
            if (w_hit) begin
              r_s_we <= m_we ? w_onehot : '0;
              r_s_re <= m_we ? '0 : w_onehot;
            end else begin
              r_ready    <= 1'b1;
              r_err      <= 1'b1;
              r_rdata    <= '0;
              r_err_addr <= m_addr;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_ack_sel) begin
            r_s_re  <= '0;
            r_s_we  <= '0;
            r_ready <= 1'b1;
            if (!r_wr) r_rdata <= w_rdata_sel;
          end else if (w_timeout) begin
            r_s_re     <= '0;
            r_s_we     <= '0;
            r_ready    <= 1'b1;
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
            if (!r_wr) r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_rdata   = r_rdata;
  assign m_ready   = r_ready;
  assign m_err     = r_err;
  assign err_addr  = r_err_addr;
  assign s_re      = r_s_re;
  assign s_we      = r_s_we;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign s_op      = r_op;
  assign dbg_state = r_state;

endmodule
